arb_mux_n: RTL and testbench
============================

# arb_mux_n

Parametrised N-channel registered stream multiplexer with valid/ready handshakes and round-robin arbitration. It is the successor to the plain combinational 4:1 mux. It merges several producer streams, such as writeback sources or memory request ports, onto one registered consumer port. It reports which channel each beat came from. Each accepted beat appears at the output one cycle later, and one beat per cycle is sustained.

## Interface
Parameters:
- DATA_WIDTH, 32, width of each channel's data.
- NUM_CH, 4, number of input channels. Legal range 2..16; need not be a power of two.
- SEL_WIDTH, derived localparam equal to $clog2(NUM_CH). It is not overridable.

Ports:
- clk_i  input  1  clock. All state changes on its rising edge.
- rst_ni  input  1  reset. Asynchronous, active-low.
- in_data_i  input  NUM_CH*DATA_WIDTH  flattened channel data. Channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_valid_i  input  NUM_CH  per-channel valid.
- in_ready_o  output  NUM_CH  per-channel ready. It is one-hot or zero.
- out_data_o  output  DATA_WIDTH  registered output data.
- out_sel_o  output  SEL_WIDTH  index of the channel that supplied out_data_o.
- out_valid_o  output  1  output beat valid.
- out_ready_i  input  1  consumer ready.

## Operation
- Transfer rule: a transfer occurs on any port where valid and ready are both high at a rising edge. Producers hold data stable while valid is high and ready is low. The consumer may deassert out_ready_i at any time.
- Output register: one beat deep. The state is EMPTY (out_valid_o=0) or FULL (out_valid_o=1).
- Free condition: free = !out_valid_o || out_ready_i. This is a combinational dependence of in_ready_o on out_ready_i.
- Grant: when free and at least one in_valid_i bit is set, exactly one channel g is granted and in_ready_o[g]=1. All other in_ready_o bits are 0.
  - If not free, all in_ready_o bits are 0.
  - While rst_ni is low, in_ready_o is forced to 0.
- Round-robin: the search starts at pointer p and proceeds p, p+1, …, NUM_CH-1, 0, …, p-1. The first channel with valid set wins.
  - After a transfer from channel g, p becomes g+1, wrapping to 0 after NUM_CH-1.
  - p is unchanged when no transfer occurs.
- Capture: on an input transfer, out_data_o takes the granted channel's data, out_sel_o takes g, and out_valid_o is set to 1.
- State transitions:
  - EMPTY, input transfer: go to FULL.
  - FULL, output transfer and no input transfer: go to EMPTY.
  - FULL, output transfer and input transfer in the same cycle: stay FULL and load the new beat.
  - FULL, out_ready_i=0: hold data and sel unchanged.
- Width rules: out_sel_o never exceeds NUM_CH-1. p is SEL_WIDTH bits wide and wraps explicitly at NUM_CH-1, not by overflow.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_sel_o=0, p=0, in_ready_o=0.
- Reset mid-operation: a held beat is discarded and is not presented after reset is released.
- Latency: an input transfer at edge N gives out_valid_o=1 from edge N until the output transfer.
- Throughput: one beat per cycle while out_ready_i stays high.
- Fairness: with all NUM_CH channels continuously valid, each channel is granted exactly once in every NUM_CH consecutive transfers.
- Combinational paths: in_valid_i→in_ready_o and out_ready_i→in_ready_o only. Data and select outputs are purely registered.

## Configuration
- ARB_MUX_FIXED_PRIO_EN defined: fixed priority. The lowest-index valid channel always wins, and the pointer register is not instantiated.
- ARB_MUX_FIXED_PRIO_EN undefined (default): round-robin as described above.
- The handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset, then in_valid_i=4'b0000 for 5 cycles.
  - Required: out_valid_o=0 and in_ready_o=0 throughout.
  - Required: in_ready_o=0 while rst_ni is low, even with in_valid_i=4'b1111.
- Single beat: channel 2 presents 0xDEADBEEF at edge N with out_ready_i=1.
  - Required: in_ready_o=4'b0100 in that cycle.
  - Required: at edge N+1, out_valid_o=1, out_data_o=0xDEADBEEF, out_sel_o=2.
  - Required: one cycle later, out_valid_o=0.
- All four channels continuously valid, data=channel index, out_ready_i=1.
  - Round-robin build: out_sel_o sequence 0,1,2,3,0,1,2,3.
  - ARB_MUX_FIXED_PRIO_EN build: sequence 0,0,0,…
- Backpressure: hold out_ready_i=0 for 3 cycles with a beat from channel 1 held.
  - Required: out_data_o and out_sel_o are stable and in_ready_o=0.
  - Required: after out_ready_i rises, the next beat loads in the same cycle the held beat leaves, and out_valid_o stays 1.
- NUM_CH=3, channels 1 and 2 continuously valid.
  - Required: out_sel_o sequence 1,2,1,2.
  - Required: the pointer wraps 2→0 without producing index 3.
- Reset mid-operation: assert rst_ni=0 while FULL with out_ready_i=0.
  - Required: out_valid_o=0 immediately (asynchronously).
  - Required: after release, the next beat comes from a channel searched starting at p=0.

Source files
------------

// File: rtl/arb_mux_n.sv
// N-channel registered stream mux with valid/ready handshakes and round-robin arbitration.
// Define ARB_MUX_FIXED_PRIO_EN to select fixed lowest-index priority; the pointer register is then removed.
module arb_mux_n #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_i,
  input  logic [NUM_CH-1:0]            in_valid_i,
  output logic [NUM_CH-1:0]            in_ready_o,
  output logic [DATA_WIDTH-1:0]        out_data_o,
  output logic [SEL_WIDTH-1:0]         out_sel_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i
);

  logic [SEL_WIDTH-1:0]  rot_idx [NUM_CH];
  logic [DATA_WIDTH-1:0] chan_data [NUM_CH];
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic                  grant_found;
  logic                  free;
  logic                  take;
  logic                  out_valid_reg;
  logic [DATA_WIDTH-1:0] out_data_reg;
  logic [SEL_WIDTH-1:0]  out_sel_reg;

`ifndef ARB_MUX_FIXED_PRIO_EN
  logic [SEL_WIDTH-1:0]  ptr_reg;
`endif

  // rot_idx[k] is the channel examined k-th in the search order.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign chan_data[gi] = in_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
`ifdef ARB_MUX_FIXED_PRIO_EN
      assign rot_idx[gi] = SEL_WIDTH'(gi);
`else
      // One extra bit so the sum never overflows before the explicit wrap.
      logic [SEL_WIDTH:0] rot_sum;
      assign rot_sum = {1'b0, ptr_reg} + (SEL_WIDTH+1)'(gi);
      assign rot_idx[gi] = (rot_sum >= (SEL_WIDTH+1)'(NUM_CH))
                         ? SEL_WIDTH'(rot_sum - (SEL_WIDTH+1)'(NUM_CH))
                         : SEL_WIDTH'(rot_sum);
`endif
    end
  endgenerate

  // Walk backwards so the earliest position in the search order wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (in_valid_i[rot_idx[i]]) begin
        grant_found = 1'b1;
        grant_idx   = rot_idx[i];
      end
    end
  end

  assign free       = !out_valid_reg || out_ready_i;
  assign take       = rst_ni && free && grant_found;
  assign in_ready_o = take ? (NUM_CH'(1) << grant_idx) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
    end else if (take) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= chan_data[grant_idx];
      out_sel_reg   <= grant_idx;
    end else if (out_ready_i) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifndef ARB_MUX_FIXED_PRIO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_reg <= '0;
    end else if (take) begin
      ptr_reg <= (grant_idx == SEL_WIDTH'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`endif

  assign out_valid_o = out_valid_reg;
  assign out_data_o  = out_data_reg;
  assign out_sel_o   = out_sel_reg;

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed scenarios plus random traffic against a behavioural model.
// A 4-channel and a 3-channel instance share clock and reset.
module tb_arb_mux_n;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [4*DW-1:0] d4;
  logic [3:0]      v4, r4;
  logic [DW-1:0]   od4;
  logic [1:0]      os4;
  logic            ov4, ordy4;

  logic [3*DW-1:0] d3;
  logic [2:0]      v3, r3;
  logic [DW-1:0]   od3;
  logic [1:0]      os3;
  logic            ov3, ordy3;

  arb_mux_n #(.DATA_WIDTH(DW), .NUM_CH(4)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(d4), .in_valid_i(v4), .in_ready_o(r4),
    .out_data_o(od4), .out_sel_o(os4), .out_valid_o(ov4), .out_ready_i(ordy4));

  arb_mux_n #(.DATA_WIDTH(DW), .NUM_CH(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .in_data_i(d3), .in_valid_i(v3), .in_ready_o(r3),
    .out_data_o(od3), .out_sel_o(os3), .out_valid_o(ov3), .out_ready_i(ordy3));

  int errors = 0;
  int checks = 0;

  // Reference model of the 4-channel instance.
  logic [DW-1:0] ch_data [4];
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_sel, m_ptr, last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr, input int n);
    int start;
    start = ptr;
`ifdef ARB_MUX_FIXED_PRIO_EN
    start = 0;
`endif
    for (int k = 0; k < n; k++)
      if (v[(start + k) % n]) return (start + k) % n;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0; last_grant = -1;
  endtask

  // Entered just after a falling edge with inputs set; returns just after the next falling edge.
  task automatic cyc4(input string tag);
    int g;
    bit fr;
    logic [3:0] exp_r;
    for (int k = 0; k < 4; k++) d4[k*DW +: DW] = ch_data[k];
    #1;
    g     = pick(v4, m_ptr, 4);
    fr    = !m_valid || ordy4;
    exp_r = (fr && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk({tag, ":in_ready"}, 64'(r4), 64'(exp_r));
    @(posedge clk);
    last_grant = -1;
    if (fr && g >= 0) begin
      m_valid = 1'b1; m_data = ch_data[g]; m_sel = g; m_ptr = (g + 1) % 4; last_grant = g;
    end else if (ordy4) begin
      m_valid = 1'b0;
    end
    #1;
    chk({tag, ":out_valid"}, 64'(ov4), 64'(m_valid));
    chk({tag, ":out_data"},  64'(od4), 64'(m_data));
    chk({tag, ":out_sel"},   64'(os4), 64'(m_sel));
    $display("%s: ready=%b valid=%0b sel=%0d data=%08h", tag, exp_r, ov4, os4, od4);
    @(negedge clk);
  endtask

  initial begin
    int exp_sel;
    int seq3 [4];
    logic [2:0] exp_r3;

    // Reset held with all channels requesting.
    rst_n = 1'b0; v4 = 4'b1111; ordy4 = 1'b1; d4 = '0;
    v3 = 3'b000; ordy3 = 1'b1; d3 = '0;
    for (int k = 0; k < 4; k++) ch_data[k] = '0;
    model_reset();
    #2;
    chk("reset:in_ready4", 64'(r4), 64'd0);
    chk("reset:out_valid4", 64'(ov4), 64'd0);
    @(negedge clk); #1;
    chk("reset_edge:in_ready4", 64'(r4), 64'd0);
    chk("reset_edge:out_data4", 64'(od4), 64'd0);
    chk("reset_edge:out_sel4", 64'(os4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; v4 = 4'b0000;
    for (int i = 0; i < 5; i++) cyc4("idle");

    // All channels continuously valid, data = channel index.
    for (int k = 0; k < 4; k++) ch_data[k] = DW'(k);
    v4 = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cyc4("allvalid");
      exp_sel = i % 4;
`ifdef ARB_MUX_FIXED_PRIO_EN
      exp_sel = 0;
`endif
      chk("allvalid:sel_seq", 64'(os4), 64'(exp_sel));
    end
    v4 = 4'b0000;
    cyc4("drain");

    // Single beat from channel 2.
    ch_data[2] = 32'hDEADBEEF; v4 = 4'b0100;
    cyc4("single");
    chk("single:data_const", 64'(od4), 64'hDEADBEEF);
    chk("single:sel_const", 64'(os4), 64'd2);
    v4 = 4'b0000;
    cyc4("single_drain");
    chk("single:valid_drop", 64'(ov4), 64'd0);

    // Backpressure with a held beat from channel 1 and another waiting.
    ch_data[1] = 32'hA5A5A5A5; v4 = 4'b0010; ordy4 = 1'b0;
    cyc4("bp_load");
    ch_data[1] = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      cyc4("bp_hold");
      chk("bp:data_stable", 64'(od4), 64'hA5A5A5A5);
      chk("bp:sel_stable", 64'(os4), 64'd1);
    end
    ordy4 = 1'b1;
    cyc4("bp_release");
    chk("bp:next_loaded", 64'(od4), 64'h11111111);
    chk("bp:valid_kept", 64'(ov4), 64'd1);

    // Asynchronous reset while FULL and stalled.
    ordy4 = 1'b0; v4 = 4'b0000;
    cyc4("pre_reset");
    rst_n = 1'b0; v4 = 4'b1111;
    #1;
    chk("midreset:out_valid_async", 64'(ov4), 64'd0);
    chk("midreset:in_ready", 64'(r4), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; v4 = 4'b1010; ordy4 = 1'b1;
    for (int k = 0; k < 4; k++) ch_data[k] = 32'hC0DE0000 + DW'(k);
    cyc4("post_reset");
    chk("midreset:search_from_0", 64'(os4), 64'd1);
    v4 = 4'b0000;
    cyc4("post_reset_drain");

    // Random traffic; producers hold valid/data until accepted.
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (!(v4[k] && last_grant != k && last_grant >= -1 && v4[k])) begin
          v4[k] = 1'($urandom_range(1, 0));
          ch_data[k] = $urandom;
        end else if (last_grant == k) begin
          v4[k] = 1'($urandom_range(1, 0));
          ch_data[k] = $urandom;
        end
      end
      ordy4 = ($urandom_range(3, 0) != 0);
      cyc4("random");
    end

    // Three-channel instance: channels 1 and 2 continuously valid.
    seq3[0] = 1; seq3[1] = 2; seq3[2] = 1; seq3[3] = 2;
`ifdef ARB_MUX_FIXED_PRIO_EN
    seq3[1] = 1; seq3[3] = 1;
`endif
    d3 = {32'h00000002, 32'h00000001, 32'h00000000};
    v3 = 3'b110; ordy3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_r3 = 3'(1 << seq3[i]);
      chk("ch3:in_ready", 64'(r3), 64'(exp_r3));
      @(posedge clk); #1;
      chk("ch3:out_sel", 64'(os3), 64'(seq3[i]));
      chk("ch3:out_data", 64'(od3), 64'(seq3[i]));
      chk("ch3:out_valid", 64'(ov3), 64'd1);
      $display("ch3: sel=%0d data=%08h", os3, od3);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
